// File: rtl/gpu_clk_pkg.sv
// Shared types and default timing for the board clock/reset sequencer.
// Defaults assume the 50 MHz board oscillator.
package gpu_clk_pkg;

  localparam int CNT_W = 16;

  localparam int DEF_SYNC_STAGES         = 2;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_SDRAM_PWRUP_CYCLES  = 10000;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_PLL_RST_CYCLES      = 16;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    PLL_RST   = 3'd1,
    STABLE    = 3'd2,
    PWRUP     = 3'd3,
    RUN       = 3'd4
  } seq_state_t;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL lock supervisor: retries the PLL on lock timeout, then releases core reset
// and signals SDRAM power-up completion; tracks lock losses after release.
module pll_reset_seq
  import gpu_clk_pkg::*;
#(
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int SDRAM_PWRUP_CYCLES  = DEF_SDRAM_PWRUP_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES
) (
  input  logic       clk_50_in,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       clear_status,
  output logic       pll_rst,
  output logic       rst_core_n,
  output logic       sdram_pwrup_done,
  output logic [2:0] seq_state,
  output logic       lock_lost,
  output logic [7:0] lock_loss_count
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(SDRAM_PWRUP_CYCLES - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic             lock_s;
  seq_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             loss;

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk_50_in),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  always_comb begin
    state_next = state;
    loss       = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_s)                    state_next = STABLE;
        else if (cnt == TIMEOUT_LAST)  state_next = PLL_RST;
      end
      PLL_RST: begin
        if (cnt == PLLRST_LAST)        state_next = WAIT_LOCK;
      end
      STABLE: begin
        // Lock has not been declared good yet, so a drop here is not a loss.
        if (!lock_s)                   state_next = WAIT_LOCK;
        else if (cnt == STABLE_LAST)   state_next = PWRUP;
      end
      PWRUP: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          loss       = 1'b1;
        end else if (cnt == PWRUP_LAST) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          loss       = 1'b1;
        end
      end
      default: state_next = WAIT_LOCK;
    endcase

    // RUN has no timeout, so the counter simply parks there.
    if (state_next != state)  cnt_next = '0;
    else if (state == RUN)    cnt_next = cnt;
    else                      cnt_next = cnt + 1'b1;
  end

  // Outputs are decoded from state_next so they switch on the same edge as state.
  always_ff @(posedge clk_50_in or negedge rst_n) begin
    if (!rst_n) begin
      state            <= WAIT_LOCK;
      cnt              <= '0;
      pll_rst          <= 1'b0;
      rst_core_n       <= 1'b0;
      sdram_pwrup_done <= 1'b0;
      lock_lost        <= 1'b0;
      lock_loss_count  <= 8'd0;
    end else begin
      state            <= state_next;
      cnt              <= cnt_next;
      pll_rst          <= (state_next == PLL_RST);
      rst_core_n       <= (state_next == PWRUP) || (state_next == RUN);
      sdram_pwrup_done <= (state_next == RUN);
      if (loss) begin
        lock_lost       <= 1'b1;
        lock_loss_count <= clear_status ? 8'd1 : sat_inc(lock_loss_count);
      end else if (clear_status) begin
        lock_lost       <= 1'b0;
        lock_loss_count <= 8'd0;
      end
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with shortened timing parameters.
module tb_pll_reset_seq;

  logic       clk_50_in = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       clear_status;
  logic       pll_rst;
  logic       rst_core_n;
  logic       sdram_pwrup_done;
  logic [2:0] seq_state;
  logic       lock_lost;
  logic [7:0] lock_loss_count;

  int checks = 0;
  int errors = 0;

  pll_reset_seq #(
    .SYNC_STAGES         (2),
    .LOCK_STABLE_CYCLES  (8),
    .SDRAM_PWRUP_CYCLES  (20),
    .LOCK_TIMEOUT_CYCLES (50),
    .PLL_RST_CYCLES      (4)
  ) dut (
    .clk_50_in        (clk_50_in),
    .rst_n            (rst_n),
    .pll_locked       (pll_locked),
    .clear_status     (clear_status),
    .pll_rst          (pll_rst),
    .rst_core_n       (rst_core_n),
    .sdram_pwrup_done (sdram_pwrup_done),
    .seq_state        (seq_state),
    .lock_lost        (lock_lost),
    .lock_loss_count  (lock_loss_count)
  );

  always #5 clk_50_in = ~clk_50_in;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".pll_rst"},    16'(pll_rst),          16'd0);
    chk({tag, ".rst_core_n"}, 16'(rst_core_n),       16'd0);
    chk({tag, ".pwrup_done"}, 16'(sdram_pwrup_done), 16'd0);
    chk({tag, ".state"},      16'(seq_state),        16'd0);
    chk({tag, ".lock_lost"},  16'(lock_lost),        16'd0);
    chk({tag, ".count"},      16'(lock_loss_count),  16'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    clear_status = 1'b0;
    #3;
    chk_reset_vals("reset");
    tick(1);
    rst_n = 1'b1;

    // Lock never arrives: 50 cycles waiting, 4-cycle PLL reset, repeat.
    tick(49);
    chk("timeout.pre_rst", 16'(pll_rst), 16'd0);
    tick(1);
    chk("timeout.pll_rst_hi", 16'(pll_rst), 16'd1);
    chk("timeout.state_pllrst", 16'(seq_state), 16'd1);
    tick(3);
    chk("timeout.pll_rst_4th", 16'(pll_rst), 16'd1);
    tick(1);
    chk("timeout.pll_rst_lo", 16'(pll_rst), 16'd0);
    chk("timeout.state_wait", 16'(seq_state), 16'd0);
    tick(49);
    chk("timeout2.pre_rst", 16'(pll_rst), 16'd0);
    tick(1);
    chk("timeout2.pll_rst_hi", 16'(pll_rst), 16'd1);
    tick(3);
    chk("timeout2.pll_rst_4th", 16'(pll_rst), 16'd1);
    tick(1);
    chk("timeout2.pll_rst_lo", 16'(pll_rst), 16'd0);

    // Lock arrives, then glitches low for 3 cycles during STABLE.
    pll_locked = 1'b1;
    tick(2);
    chk("lock.still_wait", 16'(seq_state), 16'd0);
    tick(1);
    chk("lock.stable", 16'(seq_state), 16'd2);
    tick(2);
    pll_locked = 1'b0;
    tick(3);
    chk("glitch.wait", 16'(seq_state), 16'd0);
    chk("glitch.lock_lost", 16'(lock_lost), 16'd0);
    chk("glitch.count", 16'(lock_loss_count), 16'd0);
    pll_locked = 1'b1;
    tick(10);
    chk("relock.core_lo", 16'(rst_core_n), 16'd0);
    tick(1);
    chk("relock.core_hi", 16'(rst_core_n), 16'd1);
    chk("relock.pwrup", 16'(seq_state), 16'd3);
    tick(19);
    chk("relock.done_lo", 16'(sdram_pwrup_done), 16'd0);
    tick(1);
    chk("relock.done_hi", 16'(sdram_pwrup_done), 16'd1);
    chk("relock.run", 16'(seq_state), 16'd4);

    // Lock drops in RUN.
    pll_locked = 1'b0;
    tick(2);
    chk("drop.core_still_hi", 16'(rst_core_n), 16'd1);
    tick(1);
    chk("drop.core_lo", 16'(rst_core_n), 16'd0);
    chk("drop.done_lo", 16'(sdram_pwrup_done), 16'd0);
    chk("drop.lock_lost", 16'(lock_lost), 16'd1);
    chk("drop.count", 16'(lock_loss_count), 16'd1);
    chk("drop.wait", 16'(seq_state), 16'd0);
    pll_locked = 1'b1;
    tick(11);
    chk("seq2.core_hi", 16'(rst_core_n), 16'd1);
    tick(20);
    chk("seq2.done_hi", 16'(sdram_pwrup_done), 16'd1);
    chk("seq2.lock_lost_sticky", 16'(lock_lost), 16'd1);

    // Many more losses (each taken from PWRUP) saturate the counter.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      tick(3);
      pll_locked = 1'b1;
      tick(11);
    end
    chk("sat.count", 16'(lock_loss_count), 16'd255);
    chk("sat.pwrup", 16'(seq_state), 16'd3);

    // Clear coinciding with a loss: the loss wins.
    pll_locked = 1'b0;
    tick(2);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    chk("clr_loss.count", 16'(lock_loss_count), 16'd1);
    chk("clr_loss.lock_lost", 16'(lock_lost), 16'd1);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    chk("clr.count", 16'(lock_loss_count), 16'd0);
    chk("clr.lock_lost", 16'(lock_lost), 16'd0);

    // Asynchronous reset in the middle of PWRUP.
    pll_locked = 1'b1;
    tick(11);
    chk("prerst.pwrup", 16'(seq_state), 16'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    tick(1);
    rst_n = 1'b1;
    tick(10);
    chk("restart.core_lo", 16'(rst_core_n), 16'd0);
    tick(1);
    chk("restart.core_hi", 16'(rst_core_n), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, number of flops synchronizing pll_locked.
REQ-002 SHALL provide parameter LOCK_STABLE_CYCLES, default 1024, number of cycles lock must hold before core reset release.
REQ-003 SHALL provide parameter SDRAM_PWRUP_CYCLES, default 10000, SDRAM power-up wait (200 us at 50 MHz).
REQ-004 SHALL provide parameter LOCK_TIMEOUT_CYCLES, default 50000, maximum wait for lock before a PLL reset.
REQ-005 SHALL provide parameter PLL_RST_CYCLES, default 16, width of the PLL reset pulse.
REQ-006 SHALL provide port clk_50_in, input, 1, board oscillator clock; one clock only.
REQ-007 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL provide port pll_locked, input, 1, PLL lock, asynchronous to clk_50_in.
REQ-009 SHALL provide port clear_status, input, 1, synchronous clear of the lock-loss status.
REQ-010 SHALL provide port pll_rst, output, 1, active-high reset to the PLL RST pin.
REQ-011 SHALL provide port rst_core_n, output, 1, active-low reset for the core, pixel and TMDS domains.
REQ-012 SHALL provide port sdram_pwrup_done, output, 1, SDRAM power-up wait complete.
REQ-013 SHALL provide port seq_state, output, 3, current state encoding.
REQ-014 SHALL provide port lock_lost, output, 1, sticky flag for loss of lock after reset release.
REQ-015 SHALL provide port lock_loss_count, output, 8, saturating count of lock losses.

Function
REQ-016 SHALL define lock_s as pll_locked after a SYNC_STAGES-flop synchronizer; all decisions SHALL use lock_s only.
REQ-017 SHALL implement states WAIT_LOCK, PLL_RST, STABLE, PWRUP, RUN with one 16-bit cycle counter, cleared on every state change.
REQ-018 WAIT_LOCK: on lock_s=1, SHALL go to STABLE; otherwise, when cnt==LOCK_TIMEOUT_CYCLES-1, SHALL go to PLL_RST; lock_s wins if both conditions are true.
REQ-019 PLL_RST: pll_rst=1; when cnt==PLL_RST_CYCLES-1, SHALL go to WAIT_LOCK.
REQ-020 STABLE: on lock_s=0, SHALL go to WAIT_LOCK without counting a loss; when cnt==LOCK_STABLE_CYCLES-1, SHALL go to PWRUP.
REQ-021 PWRUP: rst_core_n=1; when cnt==SDRAM_PWRUP_CYCLES-1, SHALL go to RUN.
REQ-022 RUN: rst_core_n=1 and sdram_pwrup_done=1.
REQ-023 In PWRUP or RUN, lock_s=0 SHALL force WAIT_LOCK, set lock_lost, and increment lock_loss_count, saturating at 255. This overrides any count-terminal transition in the same cycle.
REQ-024 All outputs SHALL be registered and decoded from next-state, so they change on the same edge as the state and are glitch-free.
REQ-025 Latency: rst_core_n SHALL rise exactly SYNC_STAGES+LOCK_STABLE_CYCLES+1 edges after pll_locked rises, given no loss.
REQ-026 Latency: rst_core_n and sdram_pwrup_done SHALL fall exactly SYNC_STAGES+1 edges after pll_locked falls.
REQ-027 clear_status SHALL zero lock_lost and lock_loss_count on the next edge; a loss in the same cycle wins (flag=1, count=1).
REQ-028 seq_state encoding SHALL be: WAIT_LOCK=0, PLL_RST=1, STABLE=2, PWRUP=3, RUN=4.

Reset
REQ-029 rst_n low SHALL asynchronously force: state WAIT_LOCK, cnt=0, synchronizer flops=0, pll_rst=0, rst_core_n=0, sdram_pwrup_done=0, lock_lost=0, lock_loss_count=0.
REQ-030 rst_n assertion mid-sequence (any state) SHALL abandon the sequence; restart SHALL be from WAIT_LOCK with full timing.

Structure
REQ-031 Package gpu_clk_pkg SHALL hold the seq_state_t enum and the default timing constants.
REQ-032 The synchronizer SHALL be sub-module cdc_sync_bit (parameter STAGES, async active-low reset); all other logic SHALL stay flat.

Verification (bench params: LOCK_STABLE_CYCLES=8, SDRAM_PWRUP_CYCLES=20, LOCK_TIMEOUT_CYCLES=50, PLL_RST_CYCLES=4)
REQ-033 Scenario: pll_locked rises at edge 10 -> rst_core_n=1 after edge 21, sdram_pwrup_done=1 after edge 41, seq_state=4.
REQ-034 Scenario: pll_locked held 0 -> pll_rst=1 for exactly 4 cycles after every 50 cycles in WAIT_LOCK, repeating.
REQ-035 Scenario: lock glitch low for 3 cycles during STABLE -> return to WAIT_LOCK, lock_lost=0, count=0, stable timer restarts.
REQ-036 Scenario: lock drops in RUN -> rst_core_n=0 and sdram_pwrup_done=0 after 3 edges, lock_lost=1, count=1; then relock -> full sequence repeats.
REQ-037 Scenario: 300 loss events -> count=255; clear_status pulsed with a simultaneous loss -> count=1, lock_lost=1.
REQ-038 Scenario: rst_n asserted mid-PWRUP -> all outputs at reset values immediately, without waiting for a clock edge.
